// File: rtl/acc_seq_pkg.sv
// Shared encodings and datapath width for the accumulator sequencer and its
// adder-subtractor.
package acc_seq_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [2:0] {
        OP_CLR  = 3'd0,
        OP_LOAD = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_MUL  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

endpackage

// File: rtl/addersubstractor16bit.sv
// 16-bit adder-subtractor: sum = input1 + input2 (I=0) or input1 - input2 (I=1).
// Overflow is reported only when S selects signed interpretation.
module addersubstractor16bit
    import acc_seq_pkg::*;
(
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             S,
    input  logic             I,
    output logic [WIDTH-1:0] sum,
    output logic             outc,
    output logic             borrow,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    // Subtraction is two's-complement addition of the inverted operand plus one.
    assign b_eff    = I ? ~input2 : input2;
    assign full     = {1'b0, input1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, I};
    assign sum      = full[WIDTH-1:0];
    assign outc     = full[WIDTH];
    assign borrow   = I & ~full[WIDTH];
    assign overflow = S & (input1[WIDTH-1] == b_eff[WIDTH-1])
                        & (sum[WIDTH-1] != input1[WIDTH-1]);

endmodule

// File: rtl/acc_sequencer16.sv
// Accumulator/operation controller driving a single shared adder-subtractor;
// MUL is a shift-add loop over that same adder.
module acc_sequencer16 #(
    parameter int WIDTH      = acc_seq_pkg::WIDTH,
    parameter int MUL_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             borrow,
    output logic             overflow,
    output logic             sticky_ovf,
    output logic             acc_zero
);

    import acc_seq_pkg::*;

    localparam int CNT_W = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    state_e state, state_nxt;

    logic [2:0]       op_q;
    logic [WIDTH-1:0] operand_q;
    logic             smode_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] result_q;
    logic             carry_q, borrow_q, ovf_q, sticky_q;
    logic [WIDTH-1:0] mcand, mplier, partial, partial_nxt;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] a_in1, a_in2, a_sum;
    logic             a_s, a_i, a_outc, a_borrow, a_ovf;
    logic             ovf_eff;

    addersubstractor16bit u_addsub (
        .input1  (a_in1),
        .input2  (a_in2),
        .S       (a_s),
        .I       (a_i),
        .sum     (a_sum),
        .outc    (a_outc),
        .borrow  (a_borrow),
        .overflow(a_ovf)
    );

    // The MUL loop borrows the adder as an unsigned accumulator of shifted
    // multiplicands; every other state presents the EXEC operands.
    always_comb begin
        a_in1 = acc;
        a_in2 = operand_q;
        a_s   = smode_q;
        a_i   = (op_q == OP_SUB);
        if (state == ST_MUL) begin
            a_in1 = partial;
            a_in2 = mcand;
            a_s   = 1'b0;
            a_i   = 1'b0;
        end
    end

    assign partial_nxt = mplier[0] ? a_sum : partial;
    assign ovf_eff     = a_ovf & smode_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (op == OP_MUL) ? ST_MUL : ST_EXEC;
            end
            ST_EXEC: state_nxt = ST_HOLD;
            ST_MUL:  if (cnt == CNT_LAST) state_nxt = ST_HOLD;
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= '0;
            operand_q <= '0;
            smode_q   <= 1'b0;
            acc       <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            borrow_q  <= 1'b0;
            ovf_q     <= 1'b0;
            sticky_q  <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            partial   <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q      <= op;
                        operand_q <= operand;
                        smode_q   <= signed_mode;
                        mcand     <= acc;
                        mplier    <= operand;
                        partial   <= '0;
                        cnt       <= '0;
                    end
                end
                ST_EXEC: begin
                    carry_q  <= 1'b0;
                    borrow_q <= 1'b0;
                    ovf_q    <= 1'b0;
                    case (op_q)
                        OP_CLR: begin
                            acc      <= '0;
                            result_q <= '0;
                            sticky_q <= 1'b0;
                        end
                        OP_LOAD: begin
                            acc      <= operand_q;
                            result_q <= operand_q;
                        end
                        OP_ADD: begin
                            acc      <= a_sum;
                            result_q <= a_sum;
                            carry_q  <= a_outc;
                            ovf_q    <= ovf_eff;
                            sticky_q <= sticky_q | ovf_eff;
                        end
                        OP_SUB: begin
                            acc      <= a_sum;
                            result_q <= a_sum;
                            borrow_q <= a_borrow;
                            ovf_q    <= ovf_eff;
                            sticky_q <= sticky_q | ovf_eff;
                        end
                        default: result_q <= acc;
                    endcase
                end
                ST_MUL: begin
                    partial <= partial_nxt;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        acc      <= partial_nxt;
                        result_q <= partial_nxt;
                        carry_q  <= 1'b0;
                        borrow_q <= 1'b0;
                        ovf_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result     = result_q;
    assign carry      = carry_q;
    assign borrow     = borrow_q;
    assign overflow   = ovf_q;
    assign sticky_ovf = sticky_q;
    assign acc_zero   = (result_q == '0);

endmodule

// File: tb/tb_acc_sequencer16.sv
// Scoreboard bench for acc_sequencer16: a reference model queues expected
// results at issue time and they are compared when out_valid appears.
module tb_acc_sequencer16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [15:0] operand;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        carry, borrow, overflow, sticky_ovf, acc_zero;

    typedef struct packed {
        logic [15:0] res;
        logic        c;
        logic        bo;
        logic        ov;
        logic        st;
        logic        z;
        logic [5:0]  lat;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_acc;
    logic        m_sticky;
    int          n_checks;
    int          n_err;

    acc_sequencer16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .operand    (operand),
        .signed_mode(signed_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .carry      (carry),
        .borrow     (borrow),
        .overflow   (overflow),
        .sticky_ovf (sticky_ovf),
        .acc_zero   (acc_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [15:0] b, input logic sm);
        exp_t        e;
        logic [16:0] s17;
        logic [31:0] p;
        e     = '0;
        e.lat = 6'd2;
        case (o)
            3'd0: begin m_acc = 16'd0; m_sticky = 1'b0; end
            3'd1: m_acc = b;
            3'd2: begin
                s17  = {1'b0, m_acc} + {1'b0, b};
                e.c  = s17[16];
                e.ov = sm & (m_acc[15] == b[15]) & (s17[15] != m_acc[15]);
                m_acc = s17[15:0];
            end
            3'd3: begin
                s17  = {1'b0, m_acc} - {1'b0, b};
                e.bo = (b > m_acc);
                e.ov = sm & (m_acc[15] != b[15]) & (s17[15] != m_acc[15]);
                m_acc = s17[15:0];
            end
            3'd4: begin
                p     = {16'd0, m_acc} * {16'd0, b};
                m_acc = p[15:0];
                e.lat = 6'd17;
            end
            default: ;
        endcase
        m_sticky = m_sticky | e.ov;
        e.res    = m_acc;
        e.st     = m_sticky;
        e.z      = (m_acc == 16'd0);
        return e;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [15:0] b, input logic sm, input int hold);
        exp_t e;
        int   edges;
        int   guard;
        sb.push_back(model(o, b, sm));
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_idle", in_ready, 1);
        in_valid    = 1'b1;
        op          = o;
        operand     = b;
        signed_mode = sm;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        op       = 3'd7;
        operand  = 16'hDEAD;
        while (!out_valid && edges < 40) begin
            chk("in_ready_busy", in_ready, 0);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk("out_valid", out_valid, 1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("latency", edges, e.lat);
        chk("result", result, e.res);
        chk("carry", carry, e.c);
        chk("borrow", borrow, e.bo);
        chk("overflow", overflow, e.ov);
        chk("sticky_ovf", sticky_ovf, e.st);
        chk("acc_zero", acc_zero, e.z);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_result", result, e.res);
            chk("hold_flags", {carry, borrow, overflow, sticky_ovf, acc_zero},
                {e.c, e.bo, e.ov, e.st, e.z});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        n_checks    = 0;
        n_err       = 0;
        m_acc       = 16'd0;
        m_sticky    = 1'b0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        op          = 3'd0;
        operand     = 16'd0;
        signed_mode = 1'b0;
        out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result", result, 0);
        chk("rst_flags", {carry, borrow, overflow, sticky_ovf}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'd1, 16'd29, 1'b0, 0);
        run_op(3'd2, 16'd3, 1'b0, 0);
        run_op(3'd1, 16'd65534, 1'b0, 0);
        run_op(3'd2, 16'd65100, 1'b0, 0);
        run_op(3'd1, 16'd32400, 1'b1, 0);
        run_op(3'd2, 16'd32200, 1'b1, 2);
        run_op(3'd1, 16'd5, 1'b0, 0);
        run_op(3'd0, 16'd0, 1'b0, 0);
        run_op(3'd1, 16'd8, 1'b0, 0);
        run_op(3'd3, 16'd52, 1'b0, 0);
        run_op(3'd1, 16'd52, 1'b0, 0);
        run_op(3'd3, 16'd52, 1'b0, 0);
        run_op(3'd1, 16'd32767, 1'b1, 0);
        run_op(3'd3, 16'hFFFF, 1'b1, 0);
        run_op(3'd1, 16'd644, 1'b0, 0);
        run_op(3'd4, 16'd255, 1'b0, 5);
        run_op(3'd6, 16'd1234, 1'b0, 0);
        run_op(3'd1, 16'd3, 1'b0, 0);
        run_op(3'd4, 16'hFFFF, 1'b0, 0);

        // Reset while MUL is mid-iteration: nothing may be emitted.
        run_op(3'd1, 16'd644, 1'b0, 0);
        in_valid = 1'b1;
        op       = 3'd4;
        operand  = 16'd255;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midmul_rst_valid", out_valid, 0);
        chk("midmul_rst_in_ready", in_ready, 1);
        chk("midmul_rst_result", result, 0);
        chk("midmul_rst_zero", acc_zero, 1);
        rst_n    = 1'b1;
        m_acc    = 16'd0;
        m_sticky = 1'b0;
        seen     = 1'b0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("midmul_no_output", seen, 0);
        run_op(3'd2, 16'd5, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/acc_sequencer16.md
Name: acc_sequencer16

Overview:
Sequential accumulator/operation controller that sits directly upstream of addersubstractor16bit and is its only driver. It accepts one operation at a time over a valid/ready handshake and drives the adder-subtractor's input1/input2/S/I. It captures the adder's sum/outc/borrow/overflow into an accumulator and result register, and presents the result with flags over a second valid/ready handshake. MUL is a 16-cycle shift-add that reuses the same adder instance.

Parameters:
WIDTH, 16, datapath width; fixed at 16 to match addersubstractor16bit.
MUL_CYCLES, 16, shift-add iterations for MUL; must equal WIDTH.

Ports:
clk  input  1  single clock, all state changes on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  block can accept an operation
op  input  3  0 CLR, 1 LOAD, 2 ADD, 3 SUB, 4 MUL, 5-7 NOP
operand  input  16  operand B
signed_mode  input  1  drives adder S; selects signed overflow reporting
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
result  output  16  accumulator value after the operation
carry  output  1  unsigned carry-out (ADD only)
borrow  output  1  unsigned borrow (SUB only)
overflow  output  1  signed overflow (ADD/SUB with signed_mode=1 only)
sticky_ovf  output  1  OR of all overflow flags since last CLR or reset
acc_zero  output  1  result == 0

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, acc=0, result=0, all flags=0, sticky_ovf=0, out_valid=0. In-flight operations, including MUL mid-iteration, are discarded with no output.
- States: IDLE, EXEC, MUL, HOLD.
- in_ready = (state==IDLE). out_valid = (state==HOLD). Neither depends combinationally on in_valid or out_ready.
- IDLE: on in_valid&in_ready, latch op, operand and signed_mode. Go to MUL if op==4, else EXEC.
- EXEC (one cycle):
  - Adder is driven with input1=acc, input2=operand, S=signed_mode, I=(op==SUB).
  - CLR: acc=0, all flags=0, sticky_ovf cleared.
  - LOAD: acc=operand, flags=0.
  - ADD: acc=sum; carry=outc; borrow=0.
  - SUB: acc=sum (acc-operand mod 2^16); borrow=1 iff operand>acc unsigned; carry=0.
  - overflow = adder overflow & signed_mode for ADD/SUB, else 0.
  - NOP: acc unchanged, flags=0.
  - Next state is HOLD.
- MUL:
  - Snapshot multiplicand=acc and multiplier=operand; partial=0; counter i=0..15.
  - Each cycle: if multiplier[i], partial = partial + (multiplicand<<i) mod 2^16 via the adder (I=0, S=0).
  - After the i=15 cycle: acc=partial, all flags=0, go to HOLD. The result is the unsigned low 16 bits of the product.
- HOLD:
  - result, flags and acc_zero are held stable while out_valid=1 and out_ready=0.
  - On out_ready, go to IDLE.
- sticky_ovf is set in the same edge that writes overflow=1 and is cleared only by CLR or reset.
- Latency from the accept edge to out_valid: 2 edges for single-cycle ops, 17 edges for MUL. Best throughput is one op per 3 cycles.
- in_valid asserted outside IDLE is ignored; the requester must hold it until in_ready.

Decomposition:
- Package acc_seq_pkg holds:
  - op encodings OP_CLR/OP_LOAD/OP_ADD/OP_SUB/OP_MUL;
  - state encodings ST_IDLE/ST_EXEC/ST_MUL/ST_HOLD;
  - WIDTH.
- One sub-module: a single addersubstractor16bit instance, muxed between the EXEC and MUL operands. No second adder.

Test Plan:
- LOAD 29 then ADD 3, signed_mode=0 -> result=32, carry=0, borrow=0, overflow=0; out_valid 2 edges after each accept.
- LOAD 65534 then ADD 65100, signed_mode=0 -> result=65098, carry=1, overflow=0, sticky_ovf=0.
- LOAD 32400 then ADD 32200, signed_mode=1 -> result=64600, overflow=1, sticky_ovf=1. A following CLR -> result=0, acc_zero=1, sticky_ovf=0.
- LOAD 8 then SUB 52 -> result=65492, borrow=1, carry=0. Then LOAD 52, SUB 52 -> result=0, acc_zero=1, borrow=0.
- LOAD 644 then MUL 255 -> result=33148 exactly 17 edges after accept. Hold out_ready=0 for 5 cycles -> result/flags stable, in_ready=0 throughout.
- LOAD 644, start MUL 255, assert rst_n=0 at iteration 7 -> next edge: IDLE, result=0, out_valid=0, in_ready=1; no result emitted.
